// File: rtl/fu_issue_seq.sv
// fu_issue_seq: requester-side issue sequencer for the fu operand/result port.
// Holds an 8x16 register file, launches one operation at a time to the fu,
// waits FU_LATENCY edges, then writes the result back and pulses a response.
module fu_issue_seq #(
    parameter int FU_LATENCY = 0,
    parameter int RF_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_fs,
    input  logic [2:0]  req_rd,
    input  logic [2:0]  req_ra,
    input  logic [2:0]  req_rb,
    input  logic [15:0] req_imm,
    input  logic        req_use_imm,
    output logic [15:0] fu_a_out,
    output logic [15:0] fu_b_out,
    output logic [3:0]  fu_fs_out,
    input  logic [15:0] fu_f_in,
    input  logic        fu_z_in,
    input  logic        fu_n_in,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        rsp_z,
    output logic        rsp_n,
    output logic        busy,
    input  logic [2:0]  dbg_addr,
    output logic [15:0] dbg_data
);

    typedef enum logic {IDLE, EXEC} state_t;

    localparam logic [2:0] LAT = 3'(FU_LATENCY);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  rd_q, rd_d;
    logic [15:0] rf_q [RF_DEPTH];
    logic [15:0] rf_d [RF_DEPTH];
    logic [15:0] fu_a_q, fu_a_d;
    logic [15:0] fu_b_q, fu_b_d;
    logic [3:0]  fu_fs_q, fu_fs_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [15:0] rsp_data_q, rsp_data_d;
    logic        rsp_z_q, rsp_z_d;
    logic        rsp_n_q, rsp_n_d;
    logic [15:0] rd_a, rd_b;

    // Combinational RF read ports; R0 is hard zero regardless of storage.
    always_comb begin
        rd_a     = (req_ra == 3'd0) ? 16'h0000 : rf_q[req_ra];
        rd_b     = (req_rb == 3'd0) ? 16'h0000 : rf_q[req_rb];
        dbg_data = (dbg_addr == 3'd0) ? 16'h0000 : rf_q[dbg_addr];
    end

    // Next-state: accept in IDLE, count down the fu latency in EXEC, then retire.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rd_d        = rd_q;
        for (int i = 0; i < RF_DEPTH; i++) rf_d[i] = rf_q[i];
        fu_a_d      = fu_a_q;
        fu_b_d      = fu_b_q;
        fu_fs_d     = fu_fs_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_z_d     = rsp_z_q;
        rsp_n_d     = rsp_n_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    fu_a_d  = rd_a;
                    fu_b_d  = req_use_imm ? req_imm : rd_b;
                    fu_fs_d = req_fs;
                    rd_d    = req_rd;
                    cnt_d   = LAT;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 3'd1;
                end else begin
                    // Write lands this edge, so an op accepted next edge sees it.
                    if (rd_q != 3'd0) rf_d[rd_q] = fu_f_in;
                    rsp_data_d  = fu_f_in;
                    rsp_z_d     = fu_z_in;
                    rsp_n_d     = fu_n_in;
                    rsp_valid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset drops any in-flight op without a write or response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            rd_q        <= 3'd0;
            for (int i = 0; i < RF_DEPTH; i++) rf_q[i] <= 16'h0000;
            fu_a_q      <= 16'h0000;
            fu_b_q      <= 16'h0000;
            fu_fs_q     <= 4'h0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 16'h0000;
            rsp_z_q     <= 1'b0;
            rsp_n_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rd_q        <= rd_d;
            for (int i = 0; i < RF_DEPTH; i++) rf_q[i] <= rf_d[i];
            fu_a_q      <= fu_a_d;
            fu_b_q      <= fu_b_d;
            fu_fs_q     <= fu_fs_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_z_q     <= rsp_z_d;
            rsp_n_q     <= rsp_n_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q == EXEC);
    assign fu_a_out  = fu_a_q;
    assign fu_b_out  = fu_b_q;
    assign fu_fs_out = fu_fs_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_z     = rsp_z_q;
    assign rsp_n     = rsp_n_q;

endmodule

// File: doc/fu_issue_seq.md
Name: fu_issue_seq

Overview:
Issue sequencer on the requester side of the fu operand/result interface. It owns an 8x16 register file and accepts one operation at a time over a valid/ready request port. It drives a/b/fs to the function unit, waits a fixed FU latency, and captures f/z/n. It then writes the result back and pulses a response to the control path. It sits between the decode stage of mycpu and the fu instance.

Parameters:
FU_LATENCY, 0, edges from operand launch to valid fu result (0 = combinational fu); legal range 0..7
RF_DEPTH, 8, register count; fixed at 8 (3-bit register indices)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  sequencer can accept a request this cycle
req_fs  in  4  fu function select
req_rd  in  3  destination register
req_ra  in  3  source register A
req_rb  in  3  source register B
req_imm  in  16  immediate operand
req_use_imm  in  1  1: B operand = req_imm; 0: B operand = R[req_rb]
fu_a_out  out  16  operand A to fu (a_in)
fu_b_out  out  16  operand B to fu (b_in)
fu_fs_out  out  4  function select to fu (fs_in)
fu_f_in  in  16  fu result (f_out)
fu_z_in  in  1  fu zero flag (z_out)
fu_n_in  in  1  fu negative flag (n_out)
rsp_valid  out  1  one-cycle pulse: operation retired
rsp_data  out  16  retired result
rsp_z  out  1  retired zero flag
rsp_n  out  1  retired negative flag
busy  out  1  operation in flight
dbg_addr  in  3  debug register read index
dbg_data  out  16  combinational R[dbg_addr]

Behaviour:
- Reset (async, rst=1): state IDLE; all RF entries 0; fu_a_out, fu_b_out, fu_fs_out = 0; rsp_valid, rsp_data, rsp_z, rsp_n = 0; wait counter = 0. Any in-flight operation is dropped: no RF write and no rsp pulse.
- Register file:
  - R0 always reads 0 and writes to it are discarded.
  - Reads are combinational from the registered RF.
- States: IDLE, EXEC.
  - req_ready = (state == IDLE).
  - busy = (state == EXEC).
  - req_ready does not depend on req_valid.
- Accept edge E0 (IDLE and req_valid=1):
  - fu_a_out <= R[req_ra].
  - fu_b_out <= req_use_imm ? req_imm : R[req_rb].
  - fu_fs_out <= req_fs.
  - rd latched internally.
  - wait counter <= FU_LATENCY.
  - state <= EXEC.
- fu_a_out, fu_b_out and fu_fs_out hold stable from E0 until the next accept. They do not return to 0 between operations.
- EXEC: while counter != 0, decrement each edge. On the edge where counter == 0 (edge E0+FU_LATENCY+1):
  - fu_f_in, fu_z_in and fu_n_in are sampled.
  - R[rd] <= fu_f_in (unless rd=0).
  - rsp_data, rsp_z and rsp_n are updated.
  - rsp_valid = 1 for exactly the following cycle.
  - state <= IDLE.
- Retire latency: rsp_valid is high in cycle E0+FU_LATENCY+1. The next accept is possible at edge E0+FU_LATENCY+2, so sustained throughput is 1 op per FU_LATENCY+2 cycles.
- The retire write lands before the next accept samples the RF. A back-to-back dependent op therefore reads the new value; no forwarding logic is needed.
- rsp_data, rsp_z and rsp_n hold their last retired values until the next retire. The z/n flags come from the fu, not recomputed locally.
- Requests presented while busy are ignored. The requester must hold req_valid and its fields until accepted.
- req_ra == req_rb == req_rd is legal; operands are read before the write.
- rst asserted at any point in EXEC: immediate return to IDLE with reset values. rsp_valid does not pulse after reset release.

Test Plan:
(Bench fu model: fs 4'h2 = a+b, fs 4'h5 = a-b; z = (f==0), n = f[15]; delay FU_LATENCY edges.)
1. Reset then idle, FU_LATENCY=0 -> all RF reads (dbg_addr 0..7) = 16'h0000; req_ready=1; busy=0; rsp_valid=0; fu_* = 0.
2. Load imm: fs=2, ra=0, imm=16'h1234, use_imm=1, rd=1 -> rsp_valid exactly 1 cycle after accept; rsp_data=16'h1234, z=0, n=0; R1=16'h1234.
3. Dependent back-to-back: R1=5, R2=5; op fs=5, ra=1, rb=2, rd=3, then op fs=2, ra=3, imm=16'h8000, rd=4 -> first retire: R3=0, rsp_z=1. Second accept on the cycle after rsp_valid; R4=16'h8000, rsp_n=1, rsp_z=0.
4. FU_LATENCY=3: single op accepted at E0 -> busy=1 and req_ready=0 for 4 cycles; rsp_valid in cycle E0+4; fu_a/b/fs stable throughout. A req_valid held while busy is accepted only at E0+5.
5. Write to R0 (rd=0, imm=16'hFFFF) -> rsp_data=16'hFFFF, rsp_n=1, but dbg_data(R0)=0.
6. rst pulsed 1 cycle after accept with FU_LATENCY=3 -> no rsp_valid ever for that op; destination register remains 0; req_ready=1 in the first cycle after rst deasserts.
